// File: rtl/mul_mdc_package.sv
// Shared types and constants for the mul_mdc controller and its engine-side adapters.
package mul_mdc_package;

    localparam int MUL_MDC_CNT_LEN = 1024;

    typedef enum logic [1:0] {
        KA_IDLE,
        KA_START,
        KA_RUN,
        KA_DONE
    } state_kernel_adapter_t;

    // Adapter-to-kernel handshake bundle.
    typedef struct packed {
        logic ap_start;
    } ctrl_kernel_adapter_t;

    // Kernel-to-adapter status bundle.
    typedef struct packed {
        logic ap_done;
        logic ap_idle;
        logic ap_ready;
    } flags_kernel_adapter_t;

endpackage

// File: rtl/mul_mdc_beat_counter.sv
// Saturating beat counter with a latched per-job limit and a sticky overflow flag.
module mul_mdc_beat_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             at_limit_next_o,
    output logic             overflow_o
);

    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] cnt_next;
    logic             overflow_next;

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_next      = cnt_o;
        overflow_next = overflow_o;
        if (load_i) begin
            cnt_next      = '0;
            overflow_next = 1'b0;
        end else if (inc_i) begin
            if (cnt_o >= limit_q) begin
                overflow_next = 1'b1;
            end else begin
                cnt_next = cnt_o + 1'b1;
            end
        end
    end

    // Looks ahead so the FSM can finish on the same cycle as the last beat.
    assign at_limit_next_o = (cnt_next >= limit_q);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            cnt_o      <= '0;
            overflow_o <= 1'b0;
            limit_q    <= '0;
        end else begin
            cnt_o      <= cnt_next;
            overflow_o <= overflow_next;
            if (load_i) begin
                limit_q <= limit_i;
            end
        end
    end

endmodule

// File: rtl/mul_mdc_kernel_adapter.sv
// Engine-side responder: runs the ap_* handshake for one kernel job and counts output beats.
module mul_mdc_kernel_adapter
    import mul_mdc_package::*;
#(
    parameter  int CNT_LEN = MUL_MDC_CNT_LEN,
    localparam int CNT_W   = $clog2(CNT_LEN) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] cnt_limit_i,
    output logic             ap_start_o,
    input  logic             ap_done_i,
    input  logic             ap_idle_i,
    input  logic             ap_ready_i,
    input  logic             d_valid_i,
    input  logic             d_ready_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o,
    output logic             ready_o,
    output logic             overflow_o
);

    state_kernel_adapter_t state_q, state_d;
    ctrl_kernel_adapter_t  kctrl_q, kctrl_d;
    flags_kernel_adapter_t kflags;

    logic sync_clr;
    logic job_load;
    logic in_job;
    logic beat;
    logic at_limit_next;
    logic kdone_q, kdone_d;
    logic done_d;

    assign kflags   = '{ap_done: ap_done_i, ap_idle: ap_idle_i, ap_ready: ap_ready_i};
    assign sync_clr = rst_i | clear_i;

    assign job_load = enable_i & (state_q == KA_IDLE) & start_i & kflags.ap_idle;
    assign in_job   = (state_q == KA_START) | (state_q == KA_RUN);
    assign beat     = d_valid_i & d_ready_i & enable_i & in_job;

    // Kernel done is sticky for the job, since beats may still be draining.
    always_comb begin
        kdone_d = kdone_q;
        if (job_load) begin
            kdone_d = 1'b0;
        end else if (enable_i && in_job && kflags.ap_done) begin
            kdone_d = 1'b1;
        end
    end

    mul_mdc_beat_counter #(
        .CNT_W(CNT_W)
    ) u_beat_counter (
        .clk_i          (clk_i),
        .clear_i        (sync_clr),
        .load_i         (job_load),
        .limit_i        (cnt_limit_i),
        .inc_i          (beat),
        .cnt_o          (cnt_o),
        .at_limit_next_o(at_limit_next),
        .overflow_o     (overflow_o)
    );

    always_ff @(posedge clk_i) begin
        if (sync_clr) begin
            state_q <= KA_IDLE;
            kctrl_q <= '0;
            kdone_q <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            kctrl_q <= kctrl_d;
            kdone_q <= kdone_d;
            done_o  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (enable_i) begin
            case (state_q)
                KA_IDLE:  if (job_load) state_d = KA_START;
                KA_START: if (kflags.ap_ready) state_d = KA_RUN;
                KA_RUN:   if (kdone_d && at_limit_next) state_d = KA_DONE;
                KA_DONE:  state_d = KA_IDLE;
                default:  state_d = KA_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state; a stall in KA_DONE must not stretch the pulse.
    always_comb begin
        kctrl_d          = '0;
        kctrl_d.ap_start = (state_d == KA_START);
        done_d           = (state_d == KA_DONE) && (state_q != KA_DONE);
    end

    assign ap_start_o = kctrl_q.ap_start;
    assign ready_o    = (state_q == KA_IDLE) & kflags.ap_idle;

endmodule
